// File: rtl/mem_loader_pkg.sv
// Shared constants, state encoding and header range check for the boot loader.
// Consumed by mem_loader and mem_loader_word_pack.
package mem_loader_pkg;

  localparam int HDR_BYTES         = 4;
  localparam int MEM_DEPTH_DEFAULT = 16384;

  // Byte offsets of the header fields within a frame.
  localparam int OFF_ADDR_HI = 0;
  localparam int OFF_ADDR_LO = 1;
  localparam int OFF_CNT_HI  = 2;
  localparam int OFF_CNT_LO  = 3;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_H0   = 4'd1;
  localparam logic [3:0] ST_H1   = 4'd2;
  localparam logic [3:0] ST_H2   = 4'd3;
  localparam logic [3:0] ST_H3   = 4'd4;
  localparam logic [3:0] ST_D_HI = 4'd5;
  localparam logic [3:0] ST_D_LO = 4'd6;
  localparam logic [3:0] ST_WR   = 4'd7;
  localparam logic [3:0] ST_CHK  = 4'd8;
  localparam logic [3:0] ST_DONE = 4'd9;
  localparam logic [3:0] ST_ERR  = 4'd10;

  typedef enum logic [3:0] {
    IDLE = ST_IDLE,
    H0   = ST_H0,
    H1   = ST_H1,
    H2   = ST_H2,
    H3   = ST_H3,
    D_HI = ST_D_HI,
    D_LO = ST_D_LO,
    WR   = ST_WR,
    CHK  = ST_CHK,
    DONE = ST_DONE,
    ERR  = ST_ERR
  } state_t;

  // Rejects a header whose address has bit 15 set or whose window runs past
  // the end of memory; the sum is 17 bits wide so it never wraps.
  function automatic logic range_bad(input logic [15:0] addr_word,
                                     input logic [15:0] cnt,
                                     input int          depth);
    logic [16:0] sum;
    sum = {2'b00, addr_word[14:0]} + {1'b0, cnt};
    return addr_word[15] || (sum > 17'(depth));
  endfunction

endpackage

// File: rtl/mem_loader_word_pack.sv
// Assembles HI/LO payload bytes into a 16-bit word that holds between writes.
// The running XOR of payload bytes exists only with MEM_LOADER_CHECKSUM_EN.
module mem_loader_word_pack
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        hi_en,
  input  logic        lo_en,
  input  logic [7:0]  byte_in,
`ifdef MEM_LOADER_CHECKSUM_EN
  output logic [7:0]  checksum,
`endif
  output logic [15:0] word
);

  logic [7:0]  hi_q, hi_d;
  logic [15:0] word_q, word_d;

  // The word register only changes when the LO byte lands, so the memory
  // data bus stays stable from one write to the next.
  always_comb begin
    hi_d   = hi_q;
    word_d = word_q;
    if (hi_en) hi_d = byte_in;
    if (lo_en) word_d = {hi_q, byte_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 8'h00;
      word_q <= 16'h0000;
    end else begin
      hi_q   <= hi_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) acc_d = 8'h00;
    else if (hi_en || lo_en) acc_d = acc_q ^ byte_in;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= 8'h00;
    else acc_q <= acc_d;
  end

  assign checksum = acc_q;
`endif

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream boot loader writing 16-bit words into data memory.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [7:0]        addr_lo_q, addr_lo_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic              ready_c;
  logic              load_c;
  logic              pack_clear, hi_en, lo_en;
  logic [15:0]       pack_word;
  logic [15:0]       hdr_addr;
  logic [15:0]       hdr_cnt;

  assign xfer     = byte_valid && ready_c;
  assign hdr_addr = {addr_hi_q, addr_lo_q};
  assign hdr_cnt  = {cnt_hi_q, byte_in};

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  mem_loader_word_pack u_pack (
    .clk      (clk),
    .reset    (reset),
    .clear    (pack_clear),
    .hi_en    (hi_en),
    .lo_en    (lo_en),
    .byte_in  (byte_in),
`ifdef MEM_LOADER_CHECKSUM_EN
    .checksum (checksum),
`endif
    .word     (pack_word)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_out_d = addr_out_q;
    rem_d      = rem_q;
    addr_hi_d  = addr_hi_q;
    addr_lo_d  = addr_lo_q;
    cnt_hi_d   = cnt_hi_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    ready_c    = 1'b0;
    load_c     = 1'b0;
    pack_clear = 1'b0;
    hi_en      = 1'b0;
    lo_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = H0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          pack_clear = 1'b1;
        end
      end
      H0: begin
        ready_c = 1'b1;
        if (xfer) begin
          addr_hi_d = byte_in;
          state_d   = H1;
        end
      end
      H1: begin
        ready_c = 1'b1;
        if (xfer) begin
          addr_lo_d = byte_in;
          state_d   = H2;
        end
      end
      H2: begin
        ready_c = 1'b1;
        if (xfer) begin
          cnt_hi_d = byte_in;
          state_d  = H3;
        end
      end
      // The header is validated on the very cycle CNT_LO arrives.
      H3: begin
        ready_c = 1'b1;
        if (xfer) begin
          ptr_d = hdr_addr[ADDR_W-1:0];
          rem_d = hdr_cnt;
          if (range_bad(hdr_addr, hdr_cnt, MEM_DEPTH)) state_d = ERR;
          else if (hdr_cnt == 16'd0) state_d = DONE;
          else state_d = D_HI;
        end
      end
      D_HI: begin
        ready_c = 1'b1;
        if (xfer) begin
          hi_en   = 1'b1;
          state_d = D_LO;
        end
      end
      D_LO: begin
        ready_c = 1'b1;
        if (xfer) begin
          lo_en      = 1'b1;
          addr_out_d = ptr_q;
          state_d    = WR;
        end
      end
      WR: begin
        load_c = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        rem_d  = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = D_HI;
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      CHK: begin
        ready_c = 1'b1;
        if (xfer) state_d = (byte_in == checksum) ? DONE : ERR;
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      addr_out_q <= '0;
      rem_q      <= 16'd0;
      addr_hi_q  <= 8'h00;
      addr_lo_q  <= 8'h00;
      cnt_hi_q   <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_out_q <= addr_out_d;
      rem_q      <= rem_d;
      addr_hi_q  <= addr_hi_d;
      addr_lo_q  <= addr_lo_d;
      cnt_hi_q   <= cnt_hi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign byte_ready  = ready_c;
  assign mem_load    = load_c;
  assign mem_address = addr_out_q;
  assign mem_in      = pack_word;
  assign busy        = busy_q;
  assign cpu_hold    = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: directed frames plus randomized frames.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_load;
  logic [14:0] mem_address;
  logic [15:0] mem_in;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  mem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .mem_load    (mem_load),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_wr[$];
  logic [1:0]  exp_out[$];
  logic [15:0] payload[$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares every write and every end-of-frame against the queues.
  logic busy_prev = 1'b0;
  logic xfer_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_load === 1'b1) begin
      check_eq("wr_latency", 32'(xfer_prev), 32'd1);
      check_eq("ready_low_in_wr", 32'(byte_ready), 32'd0);
      if (exp_wr.size() == 0) begin
        check_eq("unexpected_write", 32'(mem_address), 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        $display("write addr=%h data=%h (expected addr=%h data=%h)", mem_address, mem_in, e.a, e.d);
        check_eq("wr_addr", 32'(mem_address), 32'(e.a));
        check_eq("wr_data", 32'(mem_in), 32'(e.d));
      end
    end
    if (busy_prev === 1'b1 && busy === 1'b0) begin
      if (exp_out.size() == 0) begin
        check_eq("unexpected_frame_end", {30'd0, done, error}, 32'hFFFFFFFF);
      end else begin
        logic [1:0] o;
        o = exp_out.pop_front();
        $display("frame end done=%b error=%b (expected %b)", done, error, o);
        check_eq("outcome_done_error", {30'd0, done, error}, {30'd0, o});
        check_eq("cpu_hold_follows_busy", 32'(cpu_hold), 32'd0);
        check_eq("writes_drained", 32'(exp_wr.size()), 32'd0);
      end
    end
    busy_prev <= busy;
    xfer_prev <= byte_valid && byte_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_eq("byte_accept_timeout", 32'(n), 32'd0);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_eq("idle_timeout", 32'(n), 32'd0);
    tick();
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, "_ctrl"}, {26'd0, byte_ready, mem_load, cpu_hold, busy, done, error}, 32'd0);
    check_eq({name, "_data"}, {1'b0, mem_address, mem_in}, 32'd0);
  endtask

  // Reference: outcome and writes derived from the frame rules alone.
  task automatic run_frame(input logic [15:0] addr, input logic [15:0] cnt, input int gap,
                           input bit bad_csum, input bit mid_start, input bit abort);
    bit         hdr_err;
    logic [7:0] x;
    logic [1:0] outc;
    x = 8'h00;
    hdr_err = addr[15] || (({2'b00, addr[14:0]} + {1'b0, cnt}) > 17'd16384);
    if (abort) outc = 2'b00;
    else if (hdr_err) outc = 2'b01;
    else if (cnt == 16'd0) outc = 2'b10;
`ifdef MEM_LOADER_CHECKSUM_EN
    else if (bad_csum) outc = 2'b01;
`endif
    else outc = 2'b10;
    exp_out.push_back(outc);
    $display("frame addr=%h cnt=%0d gap=%0d bad_csum=%0d abort=%0d expect done/error=%b",
             addr, cnt, gap, bad_csum, abort, outc);
    pulse_start();
    send_byte(addr[15:8], gap);
    send_byte(addr[7:0], gap);
    send_byte(cnt[15:8], gap);
    send_byte(cnt[7:0], gap);
    if (!hdr_err) begin
      for (int i = 0; i < int'(cnt); i++) begin
        logic [15:0] w;
        wr_t         e;
        w   = payload[i];
        e.a = addr[14:0] + 15'(i);
        e.d = w;
        exp_wr.push_back(e);
        send_byte(w[15:8], gap);
        if (mid_start && i == 0) pulse_start();
        send_byte(w[7:0], gap);
        x = x ^ w[15:8] ^ w[7:0];
        if (abort) begin
          check_eq("abort_in_wr", 32'(mem_load), 32'd1);
          reset = 1'b1;
          tick();
          check_outputs_zero("after_abort_reset");
          reset = 1'b0;
          tick();
          return;
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      if (cnt != 16'd0) send_byte(bad_csum ? (x ^ 8'h01) : x, gap);
`endif
    end
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    reset = 1'b0;
    tick();
    check_outputs_zero("idle_after_reset");

    payload = '{16'h1234, 16'hABCD};
    run_frame(16'h0010, 16'd2, 0, 1'b0, 1'b0, 1'b0);

    payload = '{16'h0007};
    run_frame(16'h3FFF, 16'd1, 0, 1'b0, 1'b0, 1'b0);
    run_frame(16'h3FFF, 16'd2, 0, 1'b0, 1'b0, 1'b0);
    run_frame(16'h8000, 16'd1, 0, 1'b0, 1'b0, 1'b0);
    run_frame(16'h0100, 16'd0, 0, 1'b0, 1'b0, 1'b0);
    run_frame(16'h0000, 16'h4001, 0, 1'b0, 1'b0, 1'b0);

    payload = '{16'h1234, 16'hABCD};
    run_frame(16'h0010, 16'd2, 5, 1'b0, 1'b1, 1'b0);

    payload = '{16'hBEEF, 16'hCAFE, 16'h0F0F};
    run_frame(16'h0200, 16'd3, 1, 1'b0, 1'b0, 1'b1);
    payload = '{16'h5555, 16'hAAAA, 16'h0102};
    run_frame(16'h0300, 16'd3, 0, 1'b0, 1'b0, 1'b0);

`ifdef MEM_LOADER_CHECKSUM_EN
    payload = '{16'h1234, 16'hABCD};
    run_frame(16'h0010, 16'd2, 0, 1'b0, 1'b0, 1'b0);
    run_frame(16'h0010, 16'd2, 0, 1'b1, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 24; k++) begin
      int          r;
      logic [15:0] a;
      logic [15:0] c;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        a = 16'h8000 | 16'($urandom_range(0, 32767));
        c = 16'($urandom_range(0, 4));
      end else if (r == 1) begin
        int back;
        back = int'($urandom_range(1, 3));
        a = 16'(16384 - back);
        c = 16'(back + int'($urandom_range(1, 3)));
      end else begin
        c = 16'($urandom_range(0, 5));
        a = 16'($urandom_range(0, 16384 - int'(c)));
      end
      payload.delete();
      for (int i = 0; i < 8; i++) payload.push_back(16'($urandom));
      run_frame(a, c, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end

    repeat (5) tick();
    check_eq("final_write_queue_empty", 32'(exp_wr.size()), 32'd0);
    check_eq("final_outcome_queue_empty", 32'(exp_out.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
